// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter feeding a single UART transmitter (IDLE -> START -> WAIT).
// Latency: accept in IDLE, tx_start_o one cycle later, back to IDLE on tx_done_i.
// Backpressure: a requester's ready is high only in IDLE when it is selected; valid may drop freely.
// Optional feature: define UART_ARB_ROUND_ROBIN_EN for alternating grants, else fixed priority to req0.
module uart_tx_arbiter #(
  parameter int WORD_BITS  = 8,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req0_valid_i,
  input  logic [WORD_BITS-1:0]  req0_data_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic [WORD_BITS-1:0]  req1_data_i,
  output logic                  req1_ready_o,
  output logic                  tx_start_o,
  output logic [WORD_BITS-1:0]  tx_data_o,
  input  logic                  tx_done_i,
  output logic                  busy_o,
  output logic                  grant_o,
  output logic [COUNT_BITS-1:0] sent_count_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [COUNT_BITS-1:0] CNT_ONE = {{(COUNT_BITS-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [WORD_BITS-1:0]  data_q, data_d;
  logic                  grant_q, grant_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  sel1;
  logic                  accept;

  // Pick a requester; ready is suppressed while reset is asserted.
  always_comb begin
`ifdef UART_ARB_ROUND_ROBIN_EN
    // On contention, grant the requester that did not win last time.
    sel1 = req1_valid_i & (~req0_valid_i | ~grant_q);
`else
    // On contention, req0 always wins.
    sel1 = req1_valid_i & ~req0_valid_i;
`endif
    accept = (state_q == IDLE) & (req0_valid_i | req1_valid_i) & ~reset_i;
  end

  assign req0_ready_o = accept & ~sel1;
  assign req1_ready_o = accept & sel1;

  // Next-state logic; tx_done_i only matters in WAIT.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = sel1 ? req1_data_i : req0_data_i;
          grant_d = sel1;
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (tx_done_i) begin
          count_d = count_q + CNT_ONE;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    start_d = accept;
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any in-flight word.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      grant_q <= 1'b1;
      count_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      count_q <= count_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_start_o   = start_q;
  assign tx_data_o    = data_q;
  assign busy_o       = busy_q;
  assign grant_o      = grant_q;
  assign sent_count_o = count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (COUNT_BITS=4 so the counter wrap is reachable).
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       busy;
  logic       grant;
  logic [3:0] sent_count;

  int         tests = 0;
  int         fails = 0;
  logic [3:0] exp_cnt;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.WORD_BITS(8), .COUNT_BITS(4)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req0_valid_i (req0_valid),
    .req0_data_i  (req0_data),
    .req0_ready_o (req0_ready),
    .req1_valid_i (req1_valid),
    .req1_data_i  (req1_data),
    .req1_ready_o (req1_ready),
    .tx_start_o   (tx_start),
    .tx_data_o    (tx_data),
    .tx_done_i    (tx_done),
    .busy_o       (busy),
    .grant_o      (grant),
    .sent_count_o (sent_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_i = 1'b1;
    req0_valid = 0; req1_valid = 0; tx_done = 0;
    req0_data = 8'h00; req1_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    exp_cnt = 4'd0;
  endtask

  // Push one word through a full transaction; a missing ready is a failure.
  task automatic send(input int which, input logic [7:0] d);
    int n = 0;
    if (which == 0) begin req0_valid = 1; req0_data = d; end
    else begin req1_valid = 1; req1_data = d; end
    #1;
    while (!((which == 0) ? req0_ready : req1_ready) && n < 50) begin
      tick(); n++;
    end
    tests++;
    if (n >= 50) begin
      fails++;
      $display("FAIL send_timeout: ready never seen for req%0d", which);
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    tx_done = 1; tick(); tx_done = 0;
    exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    req0_valid = 1; req0_data = 8'h41;
    req1_valid = 1; req1_data = 8'h55;
    tx_done = 0;
    #12;
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin fails++;
      $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end
    tests++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin fails++;
      $display("FAIL reset_tx: start=%b data=%h want 0/00", tx_start, tx_data); end
    tests++; if (busy !== 1'b0 || grant !== 1'b1 || sent_count !== 4'd0) begin fails++;
      $display("FAIL reset_state: busy=%b grant=%b cnt=%0d want 0/1/0", busy, grant, sent_count); end
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
    reset_i = 1'b0;
    exp_cnt = 4'd0;
    repeat (3) begin tx_done = 1; tick(); tx_done = 0; tick(); end
    tests++; if (sent_count !== 4'd0 || busy !== 1'b0) begin fails++;
      $display("FAIL idle_done: cnt=%0d busy=%b want 0/0", sent_count, busy); end
  endtask

  task automatic test_single();
    req0_valid = 1; req0_data = 8'h41;
    #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin fails++;
      $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready); end
    tick();
    tests++; if (tx_start !== 1'b1 || tx_data !== 8'h41 || busy !== 1'b1 || grant !== 1'b0) begin fails++;
      $display("FAIL single_start: start=%b data=%h busy=%b grant=%b want 1/41/1/0", tx_start, tx_data, busy, grant); end
    tests++; if (req0_ready !== 1'b0) begin fails++;
      $display("FAIL single_ready_start: got %b want 0", req0_ready); end
    req0_valid = 0;
    tick();
    tests++; if (tx_start !== 1'b0 || busy !== 1'b1) begin fails++;
      $display("FAIL single_wait: start=%b busy=%b want 0/1", tx_start, busy); end
    repeat (18) tick();
    tests++; if (busy !== 1'b1 || sent_count !== 4'd0 || tx_data !== 8'h41) begin fails++;
      $display("FAIL single_hold: busy=%b cnt=%0d data=%h want 1/0/41", busy, sent_count, tx_data); end
    tx_done = 1; tick(); tx_done = 0;
    exp_cnt = 4'd1;
    tests++; if (busy !== 1'b0 || sent_count !== 4'd1) begin fails++;
      $display("FAIL single_done: busy=%b cnt=%0d want 0/1", busy, sent_count); end
  endtask

  task automatic test_done_ignored();
    req0_valid = 1; req0_data = 8'h5A;
    tick();
    req0_valid = 0;
    tx_done = 1;
    tests++; if (tx_start !== 1'b1) begin fails++;
      $display("FAIL ign_start: got %b want 1", tx_start); end
    tick();
    tx_done = 0;
    tests++; if (busy !== 1'b1 || sent_count !== exp_cnt || tx_start !== 1'b0) begin fails++;
      $display("FAIL ign_done_in_start: busy=%b cnt=%0d start=%b want 1/%0d/0", busy, sent_count, tx_start, exp_cnt); end
    tick();
    tx_done = 1; tick(); tx_done = 0;
    exp_cnt = exp_cnt + 4'd1;
    tests++; if (sent_count !== exp_cnt || busy !== 1'b0) begin fails++;
      $display("FAIL ign_final: cnt=%0d busy=%b want %0d/0", sent_count, busy, exp_cnt); end
  endtask

  task automatic test_wait_pulse();
    req0_valid = 1; req0_data = 8'h77;
    tick();
    req0_valid = 0;
    tick();
    req1_valid = 1; req1_data = 8'h99;
    #1;
    tests++; if (req1_ready !== 1'b0) begin fails++;
      $display("FAIL wait_pulse_ready: got %b want 0", req1_ready); end
    tick();
    req1_valid = 0;
    tx_done = 1; tick(); tx_done = 0;
    exp_cnt = exp_cnt + 4'd1;
    repeat (3) tick();
    tests++; if (busy !== 1'b0 || tx_data !== 8'h77 || grant !== 1'b0 || sent_count !== exp_cnt) begin fails++;
      $display("FAIL wait_pulse_lost: busy=%b data=%h grant=%b cnt=%0d want 0/77/0/%0d",
               busy, tx_data, grant, sent_count, exp_cnt); end
  endtask

  task automatic test_contention();
    logic [7:0] expv [4];
    logic       exp_r1_seen;
    logic       r1_seen;
`ifdef UART_ARB_ROUND_ROBIN_EN
    expv[0] = 8'hAA; expv[1] = 8'h55; expv[2] = 8'hAA; expv[3] = 8'h55;
    exp_r1_seen = 1'b1;
`else
    expv[0] = 8'hAA; expv[1] = 8'hAA; expv[2] = 8'hAA; expv[3] = 8'hAA;
    exp_r1_seen = 1'b0;
`endif
    apply_reset();
    r1_seen = 1'b0;
    req0_valid = 1; req0_data = 8'hAA;
    req1_valid = 1; req1_data = 8'h55;
    #1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (!(req0_ready | req1_ready) && n < 50) begin
        if (req1_ready) r1_seen = 1'b1;
        tick(); n++;
      end
      if (req1_ready) r1_seen = 1'b1;
      tests++; if (n >= 50) begin fails++;
        $display("FAIL contend_timeout: transfer %0d", k); end
      tick();
      tests++; if (tx_data !== expv[k] || tx_start !== 1'b1) begin fails++;
        $display("FAIL contend_word%0d: data=%h start=%b want %h/1", k, tx_data, tx_start, expv[k]); end
      if (req1_ready) r1_seen = 1'b1;
      tick();
      tick();
      tx_done = 1; tick(); tx_done = 0;
      exp_cnt = exp_cnt + 4'd1;
    end
    req0_valid = 0; req1_valid = 0;
    tests++; if (r1_seen !== exp_r1_seen || sent_count !== 4'd4) begin fails++;
      $display("FAIL contend_summary: r1_seen=%b cnt=%0d want %b/4", r1_seen, sent_count, exp_r1_seen); end
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    req1_valid = 1; req1_data = 8'h33;
    #1;
    tick();
    req1_valid = 0;
    tick();
    tests++; if (tx_data !== 8'h33 || busy !== 1'b1) begin fails++;
      $display("FAIL rst_wait_pre: data=%h busy=%b want 33/1", tx_data, busy); end
    reset_i = 1'b1;
    tx_done = 1;
    #1;
    tests++; if (busy !== 1'b0 || tx_data !== 8'h00 || sent_count !== 4'd0 || tx_start !== 1'b0) begin fails++;
      $display("FAIL rst_wait_async: busy=%b data=%h cnt=%0d start=%b want 0/00/0/0", busy, tx_data, sent_count, tx_start); end
    tick();
    tx_done = 0;
    reset_i = 1'b0;
    exp_cnt = 4'd0;
    req0_valid = 1; req0_data = 8'h3C;
    #1;
    tests++; if (req0_ready !== 1'b1) begin fails++;
      $display("FAIL rst_wait_next_ready: got %b want 1", req0_ready); end
    tick();
    req0_valid = 0;
    tests++; if (tx_start !== 1'b1 || tx_data !== 8'h3C) begin fails++;
      $display("FAIL rst_wait_next: start=%b data=%h want 1/3C", tx_start, tx_data); end
    tick();
    tx_done = 1; tick(); tx_done = 0;
    tests++; if (sent_count !== 4'd1) begin fails++;
      $display("FAIL rst_wait_count: cnt=%0d want 1", sent_count); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      send(0, 8'(i));
      if (i == 14) begin
        tests++; if (sent_count !== 4'd15) begin fails++;
          $display("FAIL wrap_15: cnt=%0d want 15", sent_count); end
      end
    end
    tests++; if (sent_count !== 4'd0 || exp_cnt !== 4'd0) begin fails++;
      $display("FAIL wrap_0: cnt=%0d want 0", sent_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_done_ignored();
    test_wait_pulse();
    test_contention();
    test_reset_in_wait();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: WORD_BITS, default 8, data word width.
REQ-002 Parameter: COUNT_BITS, default 16, width of the sent-word counter.
REQ-003 Port: clk_i  input  1  clock; all state changes on rising edge.
REQ-004 Port: reset_i  input  1  reset, asynchronous, active-high.
REQ-005 Port: req0_valid_i  input  1  requester 0 has a word.
REQ-006 Port: req0_data_i  input  WORD_BITS  requester 0 word.
REQ-007 Port: req0_ready_o  output  1  requester 0 word accepted this cycle.
REQ-008 Port: req1_valid_i  input  1  requester 1 has a word.
REQ-009 Port: req1_data_i  input  WORD_BITS  requester 1 word.
REQ-010 Port: req1_ready_o  output  1  requester 1 word accepted this cycle.
REQ-011 Port: tx_start_o  output  1  one-cycle start pulse to the UART transmitter.
REQ-012 Port: tx_data_o  output  WORD_BITS  word held for the transmitter.
REQ-013 Port: tx_done_i  input  1  transmitter word-complete pulse.
REQ-014 Port: busy_o  output  1  high whenever the state is not IDLE.
REQ-015 Port: grant_o  output  1  index of the requester most recently granted.
REQ-016 Port: sent_count_o  output  COUNT_BITS  words completed since reset.

Function
REQ-017 States SHALL be IDLE, START and WAIT.
REQ-018 In IDLE, with either valid high, the arbiter SHALL select one requester, assert only that requester's ready combinationally in the same cycle, latch its data into tx_data_o, update grant_o, and move to START.
REQ-019 Ready outputs SHALL be low in every state except IDLE, and low in IDLE when the corresponding valid is low or the requester is not selected.
REQ-020 In START, tx_start_o SHALL be high for exactly one cycle, followed unconditionally by WAIT.
REQ-021 In WAIT, tx_data_o SHALL hold stable; on tx_done_i high the arbiter SHALL increment sent_count_o and return to IDLE.
REQ-022 tx_done_i SHALL be ignored in IDLE and START, and SHALL NOT increment the counter there.
REQ-023 Minimum spacing between accepts SHALL be: accept cycle, START cycle, WAIT cycles until done, then one IDLE cycle; back-to-back accept is not permitted.
REQ-024 sent_count_o SHALL wrap from all-ones to zero without any flag.
REQ-025 When only one valid is high, that requester SHALL be granted regardless of priority mode.
REQ-026 A valid deasserted before its ready SHALL lose nothing; no word is latched unless ready was high.

Reset
REQ-027 Asserting reset_i SHALL immediately force IDLE, tx_start_o=0, tx_data_o=0, ready outputs=0, busy_o=0, sent_count_o=0 and grant_o=1, so requester 0 wins the first contention.
REQ-028 Reset asserted in START or WAIT SHALL abandon the in-flight word without a count increment; the transmitter shares reset_i.

Configuration
REQ-029 Macro UART_ARB_ROUND_ROBIN_EN defined: with both valid high in IDLE, the requester other than grant_o SHALL be granted (alternation).
REQ-030 Macro UART_ARB_ROUND_ROBIN_EN undefined: with both valid high in IDLE, requester 0 SHALL always be granted (fixed priority); all other behaviour is identical.

Verification
REQ-031 Reset with no traffic -> all outputs 0, grant_o=1, busy_o=0; tx_done_i pulses leave sent_count_o at 0.
REQ-032 req0 valid, data 8'h41 -> req0_ready_o high one cycle, tx_start_o high the next cycle with tx_data_o=8'h41; tx_done_i 20 cycles later -> busy_o low, sent_count_o=1.
REQ-033 Both valid held, data 8'hAA (req0) / 8'h55 (req1), 4 transfers -> round-robin build sends AA,55,AA,55; fixed-priority build sends AA,AA,AA,AA with req1_ready_o never high.
REQ-034 Reset asserted in WAIT with tx_data_o=8'h33 -> IDLE, tx_data_o=0, sent_count_o unchanged at 0; the next valid word starts normally.
REQ-035 COUNT_BITS=4, 16 completed words -> sent_count_o reads 15 then wraps to 0.
REQ-036 req1 valid pulsed for one cycle while in WAIT -> req1_ready_o stays low and no transfer to req1 occurs.
